bin_to_bcd_seq: RTL

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 14 +
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_e    : controller states (IDLE, SHIFT, DONE)
//   bcd_digit_t    : one packed BCD digit
//   min_bcd_digits : decimal digits needed to show 2^width-1
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_e;

   typedef logic [3:0] bcd_digit_t;

   // Number of decimal digits in the largest unsigned value of the given width.
   function automatic int min_bcd_digits(input int width);
      longint unsigned max_v;
      int              n;
      max_v = (64'd1 << width) - 64'd1;
      n     = 1;
      while (max_v >= 64'd10) begin
         max_v = max_v / 64'd10;
         n     = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
//   digit_i : scratch digit before correction
//   digit_o : corrected digit
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t digit_i,
   output bcd_digit_t digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative (one bit per clock) binary-to-BCD converter using shift-add-3.
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : conversion request, honoured only while ready=1
//   bin_in  : unsigned binary value, captured on the accepting edge
//   ready   : high in IDLE
//   busy    : high in SHIFT
//   done    : one-cycle pulse when bcd_out is updated
//   bcd_out : packed BCD result, units digit in bits [3:0]
//
// state | meaning
// IDLE  | waiting for start; bcd_out holds the previous result
// SHIFT | one adjust+shift per cycle, WIDTH cycles in total
// DONE  | result just written to bcd_out, done=1 for this cycle
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("bin_to_bcd_seq: WIDTH=%0d outside 4..32", WIDTH);
   end

   if (DIGITS < min_bcd_digits(WIDTH)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
   end

   bcd_state_e        state_q;
   logic [BCD_W-1:0]  scratch_q, scratch_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [BCD_W-1:0]  bcd_q;
   logic              ready_q, busy_q, done_q;
   logic [BCD_W-1:0]  adj;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (scratch_q[4*g +: 4]),
         .digit_o (adj[4*g +: 4])
      );
   end

   // Adjust first, then shift; the MSB of the binary register enters the units digit.
   assign {scratch_d, shreg_d} = {adj, shreg_q} << 1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         scratch_q <= '0;
         shreg_q   <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  shreg_q   <= bin_in;
                  scratch_q <= '0;
                  cnt_q     <= '0;
                  state_q   <= SHIFT;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            SHIFT: begin
               scratch_q <= scratch_d;
               shreg_q   <= shreg_d;
               // Reaches WIDTH on the final shift; CNT_W is sized so this never wraps.
               cnt_q     <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  bcd_q   <= scratch_d;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcd_q;

endmodule
